// File: rtl/piece_queue.sv
// piece_queue: upcoming-piece buffer between the LFSR random source and the
// game-control FSM. Raw random words are reduced to a piece type, immediate
// repeats get one re-roll, and results are held in a small circular FIFO.
//
// Handshakes:
//   rnd side: a word is consumed on a rising edge where rnd_req && rnd_valid.
//     rnd_req depends only on registered count, so it never combinationally
//     follows pop or rnd_valid. A re-rolled word is still consumed.
//   pop side: pop is honoured on a rising edge only when piece_valid is high;
//     pop on an empty queue is ignored.
module piece_queue #(
  parameter int NUM_TYPES = 5,
  parameter int DEPTH     = 4,
  parameter int RW        = 5
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [RW-1:0]            rnd,
  input  logic                     rnd_valid,
  output logic                     rnd_req,
  input  logic                     pop,
  output logic [2:0]               piece,
  output logic                     piece_valid,
  output logic [2:0]               next_piece,
  output logic                     next_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               reroll_cnt,
  output logic                     o_dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Repeat-filter state: NORMAL may reject a repeat, REROLL must accept.
  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_REROLL = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [2:0]      r_last_type;
  logic [7:0]      r_reroll_cnt;

  logic            w_accept;
  logic            w_push;
  logic            w_reject;
  logic            w_pop;
  logic [RW-1:0]   w_mod;
  logic [2:0]      w_cand;
  logic [PW-1:0]   w_rd_next;

  assign rnd_req   = (r_count < CW'(DEPTH));
  assign w_accept  = rnd_req && rnd_valid;
  assign w_mod     = rnd % RW'(NUM_TYPES);
  assign w_cand    = w_mod[2:0];
  assign w_pop     = pop && (r_count != '0);
  assign w_rd_next = r_rd_ptr + PW'(1);

  // Repeat filter: decide push/reject for an accepted word and next state.
  always_comb begin
    w_push      = 1'b0;
    w_reject    = 1'b0;
    w_state_nxt = r_state;
    if (w_accept) begin
      case (r_state)
        ST_NORMAL: begin
          if (w_cand == r_last_type) begin
            w_reject    = 1'b1;
            w_state_nxt = ST_REROLL;
          end else begin
            w_push = 1'b1;
          end
        end
        ST_REROLL: begin
          w_push      = 1'b1;
          w_state_nxt = ST_NORMAL;
        end
        default: w_state_nxt = ST_NORMAL;
      endcase
    end
  end

  // Filter state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_NORMAL;
    else         r_state <= w_state_nxt;
  end

  // FIFO storage, pointers, occupancy, last pushed type and re-roll counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 3'd0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_last_type  <= 3'(NUM_TYPES);
      r_reroll_cnt <= 8'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_cand;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
        r_last_type     <= w_cand;
      end
      if (w_pop) r_rd_ptr <= w_rd_next;
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (w_reject) r_reroll_cnt <= r_reroll_cnt + 8'd1;
    end
  end

  assign count       = r_count;
  assign reroll_cnt  = r_reroll_cnt;
  assign piece_valid = (r_count != '0);
  assign next_valid  = (r_count >= CW'(2));
  assign piece       = piece_valid ? r_mem[r_rd_ptr]  : 3'd0;
  assign next_piece  = next_valid  ? r_mem[w_rd_next] : 3'd0;
  assign o_dbg_state = r_state;

endmodule
